ws2812_stream_tx: RTL and testbench

Parametrised WS2812/WS2812B serial transmitter that turns a stream of RGB888 pixels into the single-wire NRZ LED waveform. Pixels arrive through a valid/ready handshake into a one-entry prefetch buffer, so a frame is sent with no gaps between bits or LEDs. A compile-time option adds global brightness scaling. The block sits between the colour/menu pattern generators and the `led_data` pad.

---
 rtl/ws2812_stream_tx.sv | 190 +++++++++++++++++++
 tb/tb_ws2812_stream_tx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_stream_tx.sv
// WS2812/WS2812B single-wire transmitter: RGB888 pixel stream in, gap-free NRZ bit stream out.
// Optional macro WS2812_BRIGHTNESS_EN adds the 8-bit `bright` global scaling input.
module ws2812_stream_tx #(
    parameter int NUM_LEDS    = 64,
    parameter int T_BIT       = 60,
    parameter int T0H         = 15,
    parameter int T1H         = 32,
    parameter int T_RST       = 15000,
    parameter int COLOR_ORDER = 0
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        frame_start,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
`ifdef WS2812_BRIGHTNESS_EN
    input  logic [7:0]  bright,
`endif
    output logic        pix_ready,
    output logic        busy,
    output logic        frame_done,
    output logic        underrun,
    output logic        led_data
);

    localparam int CNT_MAX = (T_RST > T_BIT) ? T_RST : T_BIT;
    localparam int CW      = $clog2(CNT_MAX);
    localparam int PW      = $clog2(NUM_LEDS + 1);

    localparam logic [CW-1:0] BIT_LAST = CW'(T_BIT - 1);
    localparam logic [CW-1:0] RST_LAST = CW'(T_RST - 1);
    localparam logic [CW-1:0] T0H_C    = CW'(T0H);
    localparam logic [CW-1:0] T1H_C    = CW'(T1H);
    localparam logic [PW-1:0] N_LEDS_C = PW'(NUM_LEDS);
    localparam logic [PW-1:0] LAST_PIX = PW'(NUM_LEDS - 1);

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, LATCH} state_t;

    state_t          state_q, state_d;
    logic [23:0]     buf_q, buf_d;
    logic            buf_vld_q, buf_vld_d;
    logic [23:0]     shreg_q, shreg_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   idx_q, idx_d;
    logic [4:0]      bit_q, bit_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic            led_q, led_d;
    logic            done_q, done_d;
    logic            urun_q, urun_d;
    logic            take;
    logic [23:0]     load_word;
    logic [7:0]      chan_s [3];

`ifdef WS2812_BRIGHTNESS_EN
    logic [8:0] gain;
    assign gain = {1'b0, bright} + 9'd1;
`endif

    // Channel index 0 = B, 1 = G, 2 = R, matching the pix_data packing.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
`ifdef WS2812_BRIGHTNESS_EN
            assign chan_s[gi] = 8'(({8'd0, buf_q[8*gi +: 8]} * {7'd0, gain}) >> 8);
`else
            assign chan_s[gi] = buf_q[8*gi +: 8];
`endif
        end
    endgenerate

    assign load_word = (COLOR_ORDER == 0) ? {chan_s[1], chan_s[2], chan_s[0]}
                                          : {chan_s[2], chan_s[1], chan_s[0]};

    // LATCH is excluded so that a truncated frame never requests further pixels.
    assign pix_ready = ((state_q == FETCH) || (state_q == SHIFT)) && !buf_vld_q && (acc_q < N_LEDS_C);
    assign take      = pix_valid && pix_ready;

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        buf_vld_d = buf_vld_q;
        shreg_d   = shreg_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        bit_d     = bit_q;
        cyc_d     = cyc_q;
        done_d    = 1'b0;
        urun_d    = 1'b0;

        if (take) begin
            buf_d     = pix_data;
            buf_vld_d = 1'b1;
            acc_d     = acc_q + PW'(1);
        end

        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d   = FETCH;
                    acc_d     = '0;
                    idx_d     = '0;
                    bit_d     = '0;
                    cyc_d     = '0;
                    buf_vld_d = 1'b0;
                end
            end
            FETCH: begin
                if (buf_vld_q) begin
                    state_d   = SHIFT;
                    shreg_d   = load_word;
                    buf_vld_d = 1'b0;
                    bit_d     = '0;
                    cyc_d     = '0;
                end
            end
            SHIFT: begin
                if (cyc_q != BIT_LAST) begin
                    cyc_d = cyc_q + CW'(1);
                end else begin
                    cyc_d = '0;
                    if (bit_q != 5'd23) begin
                        bit_d   = bit_q + 5'd1;
                        shreg_d = {shreg_q[22:0], 1'b0};
                    end else begin
                        bit_d = '0;
                        if (idx_q == LAST_PIX) begin
                            state_d   = LATCH;
                            buf_vld_d = 1'b0;
                        end else if (buf_vld_q) begin
                            shreg_d   = load_word;
                            buf_vld_d = 1'b0;
                            idx_d     = idx_q + PW'(1);
                        end else begin
                            state_d   = LATCH;
                            buf_vld_d = 1'b0;
                            urun_d    = 1'b1;
                        end
                    end
                end
            end
            LATCH: begin
                if (cyc_q != RST_LAST) begin
                    cyc_d = cyc_q + CW'(1);
                end else begin
                    cyc_d   = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Derived from next-state values so the registered line lines up with the bit counters.
        led_d = (state_d == SHIFT) && (cyc_d < (shreg_d[23] ? T1H_C : T0H_C));
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            buf_q     <= '0;
            buf_vld_q <= 1'b0;
            shreg_q   <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            bit_q     <= '0;
            cyc_q     <= '0;
            led_q     <= 1'b0;
            done_q    <= 1'b0;
            urun_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            buf_vld_q <= buf_vld_d;
            shreg_q   <= shreg_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            bit_q     <= bit_d;
            cyc_q     <= cyc_d;
            led_q     <= led_d;
            done_q    <= done_d;
            urun_q    <= urun_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign frame_done = done_q;
    assign underrun   = urun_q;
    assign led_data   = led_q;

endmodule

// File: tb/tb_ws2812_stream_tx.sv
// Self-checking bench for ws2812_stream_tx: expected line waveforms are built from pixel
// values with plain arithmetic and compared cycle by cycle against the captured led_data.
module tb_ws2812_stream_tx;

    localparam int NUM_LEDS    = 2;
    localparam int T_BIT       = 10;
    localparam int T0H         = 3;
    localparam int T1H         = 6;
    localparam int T_RST       = 20;
    localparam int COLOR_ORDER = 0;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        frame_start;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready, busy, frame_done, underrun, led_data;
`ifdef WS2812_BRIGHTNESS_EN
    logic [7:0]  bright;
`endif

    int tests = 0;
    int fails = 0;
    int bright_v = 255;

    logic [23:0] pq[$];
    bit          led_log[$], done_log[$], urun_log[$], busy_log[$];
    int          acc_idx, n_acc;

    always #5 sys_clk = ~sys_clk;

    ws2812_stream_tx #(
        .NUM_LEDS(NUM_LEDS), .T_BIT(T_BIT), .T0H(T0H), .T1H(T1H),
        .T_RST(T_RST), .COLOR_ORDER(COLOR_ORDER)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .frame_start(frame_start),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
`ifdef WS2812_BRIGHTNESS_EN
        .bright     (bright),
`endif
        .pix_ready  (pix_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun),
        .led_data   (led_data)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    function automatic logic at(input bit q[$], input int i);
        if (i < 0 || i >= q.size()) return 1'bx;
        return q[i];
    endfunction

    function automatic logic [7:0] scale(input logic [7:0] c);
        return 8'((32'(c) * (bright_v + 1)) >> 8);
    endfunction

    // Runs one frame from the current negedge; logs one sample per cycle until frame_done.
    task automatic run_frame(input int first_delay, input bit hold_after_first, input int extra_start_at);
        bit hs;
        int sent  = 0;
        int guard = 0;
        bit got_done = 0;
        led_log.delete(); done_log.delete(); urun_log.delete(); busy_log.delete();
        acc_idx     = -1;
        frame_start = 1'b1;
        pix_data    = pq[0];
        pix_valid   = (first_delay == 0);
        while (!got_done && guard < 3000) begin
            hs = pix_valid && pix_ready;
            @(negedge sys_clk);
            guard++;
            if (hs) begin
                if (sent == 0) acc_idx = led_log.size();
                sent++;
                if (!hold_after_first && sent < pq.size()) begin
                    pix_data = pq[sent];
                end else begin
                    pix_valid = 1'b0;
                    pix_data  = 24'($urandom);
                end
            end
            led_log.push_back(led_data);
            done_log.push_back(frame_done);
            urun_log.push_back(underrun);
            busy_log.push_back(busy);
            got_done    = frame_done;
            frame_start = (led_log.size() == extra_start_at);
            if (sent == 0 && led_log.size() == first_delay) pix_valid = 1'b1;
        end
        n_acc       = sent;
        frame_start = 1'b0;
        pix_valid   = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int first_delay, input int exp_sent, input bit exp_urun);
        bit exp_w[$];
        logic [7:0] ch[3];
        int errs = 0, bad_at = -1, pre_high = 0;
        int done_at = -1, done_cnt = 0, urun_at = -1, urun_cnt = 0;
        int exp_acc, exp_done;
        exp_w.push_back(1'b0);
        for (int p = 0; p < exp_sent; p++) begin
            if (COLOR_ORDER == 0) begin
                ch[0] = scale(pq[p][15:8]); ch[1] = scale(pq[p][23:16]);
            end else begin
                ch[0] = scale(pq[p][23:16]); ch[1] = scale(pq[p][15:8]);
            end
            ch[2] = scale(pq[p][7:0]);
            for (int c = 0; c < 3; c++)
                for (int b = 7; b >= 0; b--)
                    for (int t = 0; t < T_BIT; t++)
                        exp_w.push_back(t < (ch[c][b] ? T1H : T0H));
        end
        for (int t = 0; t < T_RST; t++) exp_w.push_back(1'b0);

        for (int i = 0; i < exp_w.size(); i++)
            if (at(led_log, acc_idx + i) !== exp_w[i]) begin
                errs++;
                if (bad_at < 0) bad_at = i;
            end
        for (int i = 0; i < acc_idx && i < led_log.size(); i++) pre_high += led_log[i];
        for (int i = 0; i < done_log.size(); i++) begin
            if (done_log[i]) begin done_cnt++; if (done_at < 0) done_at = i; end
            if (urun_log[i]) begin urun_cnt++; if (urun_at < 0) urun_at = i; end
        end
        exp_acc  = (first_delay == 0) ? 1 : first_delay;
        exp_done = exp_acc + exp_w.size();

        chk({tag, "/busy_start"}, 32'(at(busy_log, 0)), 1);
        chk({tag, "/accept_idx"}, acc_idx, exp_acc);
        chk({tag, "/pix_accepted"}, n_acc, exp_sent);
        chk({tag, "/fetch_led_highs"}, pre_high, 0);
        chk({tag, "/led_at_accept"}, 32'(at(led_log, acc_idx)), 0);
        chk({tag, "/first_high"}, 32'(at(led_log, acc_idx + 1)), 1);
        chk({tag, "/wave_bad_cycles"}, errs, 0);
        if (errs != 0) $display("[TB] %s first waveform difference at offset %0d", tag, bad_at);
        chk({tag, "/done_at"}, done_at, exp_done);
        chk({tag, "/done_count"}, done_cnt, 1);
        chk({tag, "/underrun_count"}, urun_cnt, 32'(exp_urun));
        chk({tag, "/underrun_at"}, urun_at, exp_urun ? exp_acc + 1 + exp_sent * 24 * T_BIT : -1);
        chk({tag, "/busy_at_done"}, 32'(at(busy_log, done_at)), 0);
        chk({tag, "/busy_before_done"}, 32'(at(busy_log, done_at - 1)), 1);
    endtask

    initial begin
        int act;
        int highs;
        sys_rst_n = 1'b0; frame_start = 1'b0; pix_valid = 1'b0; pix_data = '0;
`ifdef WS2812_BRIGHTNESS_EN
        bright = 8'(bright_v);
`endif
        // Reset values
        repeat (3) @(negedge sys_clk);
        chk("rst/led_data", 32'(led_data), 0);
        chk("rst/busy", 32'(busy), 0);
        chk("rst/pix_ready", 32'(pix_ready), 0);
        chk("rst/frame_done", 32'(frame_done), 0);
        chk("rst/underrun", 32'(underrun), 0);
        sys_rst_n = 1'b1;
        act = 0;
        repeat (100) begin
            @(negedge sys_clk);
            act += led_data + busy + pix_ready + frame_done + underrun;
        end
        chk("idle/activity", act, 0);
        chk("idle/led_data", 32'(led_data), 0);
        chk("idle/busy", 32'(busy), 0);
        chk("idle/pix_ready", 32'(pix_ready), 0);

        // Back-to-back frame
        pq = '{24'hFF0000, 24'h00FF01};
        run_frame(0, 1'b0, -1);
        $display("[TB] b2b: %0d pixels, accept at %0d, %0d samples", n_acc, acc_idx, led_log.size());
        check_frame("b2b", 0, 2, 1'b0);
        highs = 0;
        for (int t = 0; t < T_BIT; t++) highs += at(led_log, acc_idx + 1 + 47 * T_BIT + t);
        chk("b2b/last_bit_highs", highs, T1H);

        // Underrun; started in the frame_done cycle of the previous frame
        pq = '{24'($urandom)};
        run_frame(0, 1'b1, -1);
        $display("[TB] underrun: pixel %06h, %0d samples", pq[0], led_log.size());
        check_frame("urun", 0, 1, 1'b1);

        // FETCH stall with a frame_start during SHIFT
        @(negedge sys_clk);
        pq = '{24'($urandom), 24'($urandom)};
        run_frame(50, 1'b0, 150);
        $display("[TB] stall: pixels %06h %06h, accept at %0d", pq[0], pq[1], acc_idx);
        check_frame("stall", 50, 2, 1'b0);

        // Randomised frames
        for (int k = 0; k < 3; k++) begin
            int d;
            d  = $urandom_range(0, 20);
            pq = '{24'($urandom), 24'($urandom)};
            @(negedge sys_clk);
            run_frame(d, 1'b0, d + 2 + $urandom_range(0, 400));
            $display("[TB] rand%0d: delay %0d pixels %06h %06h", k, d, pq[0], pq[1]);
            check_frame($sformatf("rand%0d", k), d, 2, 1'b0);
        end

        // Reset mid-frame during bit 5
        @(negedge sys_clk);
        frame_start = 1'b1; pix_valid = 1'b1; pix_data = 24'hFF0000;
        @(negedge sys_clk);
        frame_start = 1'b0;
        @(negedge sys_clk);
        pix_valid = 1'b0;
        repeat (52) @(negedge sys_clk);
        chk("rstmid/led_before", 32'(led_data), 1);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("rstmid/led_data", 32'(led_data), 0);
        chk("rstmid/busy", 32'(busy), 0);
        chk("rstmid/pix_ready", 32'(pix_ready), 0);
        chk("rstmid/frame_done", 32'(frame_done), 0);
        chk("rstmid/underrun", 32'(underrun), 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);
        pq = '{24'hFF0000, 24'h00FF01};
        run_frame(0, 1'b0, -1);
        $display("[TB] after reset: %0d pixels, %0d samples", n_acc, led_log.size());
        check_frame("post_rst", 0, 2, 1'b0);

`ifdef WS2812_BRIGHTNESS_EN
        @(negedge sys_clk);
        bright_v = 127;
        bright   = 8'(bright_v);
        pq = '{24'h80FF40, 24'($urandom)};
        run_frame(0, 1'b0, -1);
        $display("[TB] bright %0d: pixels %06h %06h", bright_v, pq[0], pq[1]);
        check_frame("bright", 0, 2, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
